spi_bootcmd_monitor: RTL
========================

// Module: spi_bootcmd_monitor
// PURPOSE
//  Watches the ESP32-to-FPGA SPI link (mode 0, MSB first) in the clk domain and feeds
//  the reconfiguration timer. keepalive_n (low = activity) drives the timer's esp_cs_n.
//  Also decodes the first byte of each frame: CMD_BOOT requests an immediate jump to
//  the user image (boot_now); any other complete byte is reported on cmd_byte.
// PARAMETERS
//  CLOCK_MHZ     27     clk frequency in MHz; documentation/assert only
//  SYNC_STAGES   2      flops per synchroniser on spi_cs_n/spi_sck/spi_mosi (>=2)
//  STRETCH_CLKS  1024   clk cycles keepalive_n stays low after spi_cs_n deasserts
//  CMD_BOOT      8'hB0  first-byte opcode requesting boot_now
// PORTS
//  clk          in   1  system clock, sole clock domain
//  rst          in   1  synchronous, active-high reset
//  spi_cs_n     in   1  async SPI chip select from ESP32, active low
//  spi_sck      in   1  async SPI clock; max freq clk/4
//  spi_mosi     in   1  async SPI data, sampled on SCK rising edge
//  keepalive_n  out  1  low while a frame is active or being stretched
//  cmd_valid    out  1  1-clk pulse: cmd_byte holds a new first byte
//  cmd_byte     out  8  first byte of the last complete frame
//  boot_now     out  1  1-clk pulse: frame closed with first byte == CMD_BOOT
//  err_frame    out  1  1-clk pulse: CS deasserted with 1..7 bits received
// BEHAVIOUR
//  - Reset: keepalive_n=1, cmd_valid=0, cmd_byte=8'h00, boot_now=0, err_frame=0,
//    stretch counter=0, synchroniser flops=1 (idle), FSM -> RESYNC.
//  - Inputs pass through SYNC_STAGES flops; edges detected from the last two stages.
//    cs_act = synced CS low. sck_rise = synced SCK 0->1.
//  - FSM:
//    RESYNC: wait for cs_act=0, then IDLE. Prevents a misaligned byte after a reset
//            mid-frame. No cmd/err pulses in this state.
//    IDLE:   cs_act 1 -> SHIFT; bit_cnt=0; shreg cleared.
//    SHIFT:  on sck_rise: shreg <= {shreg[6:0], mosi_sync}; bit_cnt++.
//            When bit_cnt reaches 8: cmd_byte <= shreg value, cmd_valid pulses the
//            next cycle -> HOLD. On cs_act falling with bit_cnt 1..7: err_frame
//            pulse -> IDLE. bit_cnt 0: silent -> IDLE.
//    HOLD:   ignore further bits. On cs_act falling: boot_now pulse if
//            cmd_byte == CMD_BOOT -> IDLE.
//  - If CS deasserts and reasserts in consecutive clks, a new frame starts normally.
//  - keepalive_n = ~(cs_act | (stretch != 0)), registered, 1 clk after synced CS.
//    stretch loads STRETCH_CLKS-1 on the cs_act falling edge, then decrements to 0
//    and saturates. A new cs_act during stretch holds keepalive_n low, and the
//    counter reloads at the next falling edge. Counts during RESYNC too.
//  - Latency from a pin edge to its effect: SYNC_STAGES+1 clk (+1 for registered pulses).
//  - Pulses are exactly one clk wide. boot_now and err_frame are mutually exclusive.
//  - Counter widths come from clog2 of the parameter and must not wrap.
// STRUCTURE
//  - Shared package/header: FSM state encodings (RESYNC, IDLE, SHIFT, HOLD) and the
//    default opcode CMD_BOOT. The Verilog-2001 clog2 function moves to a common
//    include used by this block and the restart timer.
//  - One sub-module: sync_edge (N-flop synchroniser with rise/fall strobes), three
//    instances.
//  - FSM, shift register and stretch counter are local.
// TESTING
//  1 Reset with CS high: all outputs at reset values. keepalive_n=1 after 1 clk.
//  2 Frame 0xB0, SCK=clk/8 -> cmd_valid with cmd_byte=8'hB0, then boot_now 1 clk
//    after synced CS rise. keepalive_n low throughout and STRETCH_CLKS after.
//  3 Frame 0xA5,0xFF (16 bits) -> cmd_byte=8'hA5, one cmd_valid, no boot_now, no err.
//  4 CS low, 5 SCK edges, CS high -> err_frame=1 for 1 clk. No cmd_valid.
//    cmd_byte keeps its previous value.
//  5 Assert rst after 3 bits of a frame, keep CS low 4 more bits -> no cmd_valid or
//    err_frame. Next full 0xB0 frame -> boot_now.
//  6 Two frames 10 clks apart with STRETCH_CLKS=16 -> keepalive_n stays continuously
//    low. Rises exactly 16 clks after the second synced CS rise.

Source files
------------

// File: rtl/spi_bootcmd_monitor_pkg.sv
// Shared types and helpers for the SPI boot-command monitor: FSM encoding,
// default boot opcode and a width helper shared with the restart timer.
package spi_bootcmd_monitor_pkg;

    typedef enum logic [1:0] {
        ST_RESYNC = 2'd0,
        ST_IDLE   = 2'd1,
        ST_SHIFT  = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    localparam logic [7:0] CMD_BOOT_DEFAULT = 8'hB0;

    // Bits needed to hold values 0..value-1, never less than one bit.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/spi_bootcmd_monitor_if.sv
// SPI pins from the ESP32 plus the monitor's decoded outputs toward the
// reconfiguration timer and boot logic.
interface spi_bootcmd_monitor_if;
    logic       spi_cs_n;
    logic       spi_sck;
    logic       spi_mosi;
    logic       keepalive_n;
    logic       cmd_valid;
    logic [7:0] cmd_byte;
    logic       boot_now;
    logic       err_frame;

    modport master (
        output spi_cs_n, spi_sck, spi_mosi,
        input  keepalive_n, cmd_valid, cmd_byte, boot_now, err_frame
    );

    modport slave (
        input  spi_cs_n, spi_sck, spi_mosi,
        output keepalive_n, cmd_valid, cmd_byte, boot_now, err_frame
    );
endinterface

// File: rtl/spi_bootcmd_monitor_sync_edge.sv
// N-flop synchroniser for an asynchronous pin; the rise strobe is taken from
// the last two stages, so it leads the level output by one clock.
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic level,
    output logic rise
);

    logic [STAGES-1:0] sync_q;

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = sync_q[STAGES-2] & ~sync_q[STAGES-1];

endmodule

// File: rtl/spi_bootcmd_monitor.sv
// Monitors the ESP32 SPI link: drives the reconfiguration keepalive and decodes
// the first byte of each frame into cmd_byte / boot_now / err_frame.
module spi_bootcmd_monitor
    import spi_bootcmd_monitor_pkg::*;
#(
    parameter int         CLOCK_MHZ    = 27,
    parameter int         SYNC_STAGES  = 2,
    parameter int         STRETCH_CLKS = 1024,
    parameter logic [7:0] CMD_BOOT     = CMD_BOOT_DEFAULT
) (
    input logic                  clk,
    input logic                  rst,
    spi_bootcmd_monitor_if.slave bus
);

    localparam int STRETCH_W = clog2(STRETCH_CLKS);
    localparam int SETTLE_W  = clog2(SYNC_STAGES + 1);
    localparam logic [STRETCH_W-1:0] STRETCH_LOAD = STRETCH_W'(STRETCH_CLKS - 1);
    localparam logic [SETTLE_W-1:0]  SETTLE_DONE  = SETTLE_W'(SYNC_STAGES);

    logic cs_n_q, cs_end, sck_q, sck_rise, mosi_q, mosi_rise;

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_cs   (.clk(clk), .rst(rst), .d(bus.spi_cs_n),
                                                   .level(cs_n_q), .rise(cs_end));
    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sck  (.clk(clk), .rst(rst), .d(bus.spi_sck),
                                                   .level(sck_q), .rise(sck_rise));
    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_mosi (.clk(clk), .rst(rst), .d(bus.spi_mosi),
                                                   .level(mosi_q), .rise(mosi_rise));

    logic cs_act;
    assign cs_act = ~cs_n_q;

    state_t               state_q, state_d;
    logic [7:0]           shreg_q, cmd_byte_q;
    logic [3:0]           bit_cnt_q;
    logic [STRETCH_W-1:0] stretch_q;
    logic [SETTLE_W-1:0]  settle_q;
    logic                 keepalive_n_q, cmd_valid_q, boot_now_q, err_frame_q;
    logic                 clear, shift_en, load_cmd, boot_d, err_d;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d  = state_q;
        clear    = 1'b0;
        shift_en = 1'b0;
        load_cmd = 1'b0;
        boot_d   = 1'b0;
        err_d    = 1'b0;
        unique case (state_q)
            // Synchroniser flops reset to idle, so cs_act means nothing until they refill.
            ST_RESYNC: if (settle_q == SETTLE_DONE && !cs_act) state_d = ST_IDLE;
            ST_IDLE: begin
                if (cs_act) begin
                    clear   = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cs_end) begin
                    err_d   = (bit_cnt_q != 4'd0);
                    state_d = ST_IDLE;
                end else if (sck_rise) begin
                    shift_en = 1'b1;
                    if (bit_cnt_q == 4'd7) begin
                        load_cmd = 1'b1;
                        state_d  = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (cs_end) begin
                    boot_d  = (cmd_byte_q == CMD_BOOT);
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_RESYNC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_RESYNC;
            settle_q      <= '0;
            shreg_q       <= '0;
            bit_cnt_q     <= '0;
            cmd_byte_q    <= '0;
            cmd_valid_q   <= 1'b0;
            boot_now_q    <= 1'b0;
            err_frame_q   <= 1'b0;
            stretch_q     <= '0;
            keepalive_n_q <= 1'b1;
        end else begin
            state_q <= state_d;
            if (settle_q != SETTLE_DONE) settle_q <= settle_q + 1'b1;
            if (clear) begin
                shreg_q   <= '0;
                bit_cnt_q <= '0;
            end else if (shift_en) begin
                shreg_q   <= {shreg_q[6:0], mosi_q};
                bit_cnt_q <= bit_cnt_q + 4'd1;
            end
            if (load_cmd) cmd_byte_q <= {shreg_q[6:0], mosi_q};
            cmd_valid_q <= load_cmd;
            boot_now_q  <= boot_d;
            err_frame_q <= err_d;
            // Stretch reloads on every frame end and saturates at zero.
            if (cs_end) begin
                stretch_q <= STRETCH_LOAD;
            end else if (stretch_q != '0) begin
                stretch_q <= stretch_q - 1'b1;
            end
            keepalive_n_q <= ~(cs_act | (stretch_q != '0));
        end
    end

    assign bus.keepalive_n = keepalive_n_q;
    assign bus.cmd_valid   = cmd_valid_q;
    assign bus.cmd_byte    = cmd_byte_q;
    assign bus.boot_now    = boot_now_q;
    assign bus.err_frame   = err_frame_q;

    // SCK must stay high at least two clocks (max clk/4) and MOSI must be settled at its sample.
    a_sck_high:     assert property (@(posedge clk) disable iff (rst) sck_rise |=> sck_q [*2]);
    a_mosi_stable:  assert property (@(posedge clk) disable iff (rst) sck_rise |-> !mosi_rise);
    a_param_sanity: assert property (@(posedge clk)
                                     CLOCK_MHZ > 0 && SYNC_STAGES >= 2 && STRETCH_CLKS >= 1);

endmodule
